// File: rtl/eth_tx_arb.sv
// Two-source AXI-Stream frame arbiter onto a shared MAC TX port.
// Grants are frame-atomic; ties alternate based on the last source served.
module eth_tx_arb #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              eth_clk,
    input  logic              sys_rst156,

    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic [KEEP_W-1:0] s0_tkeep,
    input  logic              s0_tlast,
    input  logic              s0_tuser,

    input  logic              s1_tvalid,
    output logic              s1_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic [KEEP_W-1:0] s1_tkeep,
    input  logic              s1_tlast,
    input  logic              s1_tuser,

    output logic              eth_tx_tvalid,
    input  logic              eth_tx_tready,
    output logic [DATA_W-1:0] eth_tx_tdata,
    output logic [KEEP_W-1:0] eth_tx_tkeep,
    output logic              eth_tx_tlast,
    output logic              eth_tx_tuser,

    input  logic [1:0]        src_en,
    output logic [31:0]       frame_cnt0,
    output logic [31:0]       frame_cnt1,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_src;
    logic       elig0;
    logic       elig1;
    logic       done0;
    logic       done1;

    assign elig0 = s0_tvalid & src_en[0];
    assign elig1 = s1_tvalid & src_en[1];

    // Frame ends on the tlast beat that actually transfers on the MAC side.
    assign done0 = (state == GNT0) & eth_tx_tvalid & eth_tx_tready & eth_tx_tlast;
    assign done1 = (state == GNT1) & eth_tx_tvalid & eth_tx_tready & eth_tx_tlast;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (elig0 && elig1)
                    state_nxt = last_src ? GNT0 : GNT1;
                else if (elig0)
                    state_nxt = GNT0;
                else if (elig1)
                    state_nxt = GNT1;
            end
            GNT0:    if (done0) state_nxt = IDLE;
            GNT1:    if (done1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Zero-latency mux; everything is forced quiet while reset is held.
    always_comb begin
        eth_tx_tvalid = 1'b0;
        eth_tx_tdata  = '0;
        eth_tx_tkeep  = '0;
        eth_tx_tlast  = 1'b0;
        eth_tx_tuser  = 1'b0;
        s0_tready     = 1'b0;
        s1_tready     = 1'b0;
        if (!sys_rst156) begin
            case (state)
                GNT0: begin
                    eth_tx_tvalid = s0_tvalid;
                    eth_tx_tdata  = s0_tdata;
                    eth_tx_tkeep  = s0_tkeep;
                    eth_tx_tlast  = s0_tlast;
                    eth_tx_tuser  = s0_tuser;
                    s0_tready     = eth_tx_tready;
                end
                GNT1: begin
                    eth_tx_tvalid = s1_tvalid;
                    eth_tx_tdata  = s1_tdata;
                    eth_tx_tkeep  = s1_tkeep;
                    eth_tx_tlast  = s1_tlast;
                    eth_tx_tuser  = s1_tuser;
                    s1_tready     = eth_tx_tready;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge eth_clk) begin
        if (sys_rst156) begin
            state      <= IDLE;
            last_src   <= 1'b1;
            frame_cnt0 <= '0;
            frame_cnt1 <= '0;
            busy       <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            if (done0) begin
                last_src   <= 1'b0;
                frame_cnt0 <= frame_cnt0 + 32'd1;
            end
            if (done1) begin
                last_src   <= 1'b1;
                frame_cnt1 <= frame_cnt1 + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: tie order, enable gating, backpressure,
// source gaps, counter wrap and mid-frame reset.
module tb_eth_tx_arb;

    logic        eth_clk = 1'b0;
    logic        sys_rst156;
    logic        s0_tvalid, s0_tready, s0_tlast, s0_tuser;
    logic [63:0] s0_tdata;
    logic [7:0]  s0_tkeep;
    logic        s1_tvalid, s1_tready, s1_tlast, s1_tuser;
    logic [63:0] s1_tdata;
    logic [7:0]  s1_tkeep;
    logic        eth_tx_tvalid, eth_tx_tready, eth_tx_tlast, eth_tx_tuser;
    logic [63:0] eth_tx_tdata;
    logic [7:0]  eth_tx_tkeep;
    logic [1:0]  src_en;
    logic [31:0] frame_cnt0, frame_cnt1;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 eth_clk = ~eth_clk;

    eth_tx_arb dut (
        .eth_clk(eth_clk), .sys_rst156(sys_rst156),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata),
        .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast), .s0_tuser(s0_tuser),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata),
        .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast), .s1_tuser(s1_tuser),
        .eth_tx_tvalid(eth_tx_tvalid), .eth_tx_tready(eth_tx_tready),
        .eth_tx_tdata(eth_tx_tdata), .eth_tx_tkeep(eth_tx_tkeep),
        .eth_tx_tlast(eth_tx_tlast), .eth_tx_tuser(eth_tx_tuser),
        .src_en(src_en), .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1),
        .busy(busy)
    );

    // Beat payload tags source, frame and beat so misrouting is visible.
    function automatic logic [63:0] mk(input int src, input int frm, input int beat);
        return {8'hA0 | 8'(src), 24'(frm), 32'(beat)};
    endfunction

    task automatic idle_inputs();
        s0_tvalid = 0; s0_tdata = '0; s0_tkeep = '0; s0_tlast = 0; s0_tuser = 0;
        s1_tvalid = 0; s1_tdata = '0; s1_tkeep = '0; s1_tlast = 0; s1_tuser = 0;
        src_en = 2'b00; eth_tx_tready = 0;
    endtask

    task automatic apply_reset();
        @(negedge eth_clk);
        sys_rst156 = 1;
        idle_inputs();
        @(negedge eth_clk);
        sys_rst156 = 0;
    endtask

    task automatic test_reset();
        @(negedge eth_clk);
        sys_rst156 = 1;
        s0_tvalid = 1; s0_tlast = 1; s0_tdata = mk(0, 0, 0); src_en = 2'b11; eth_tx_tready = 1;
        #1;
        checks++; if (eth_tx_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", eth_tx_tvalid); end
        checks++; if (s0_tready !== 1'b0) begin failures++; $display("FAIL rst_s0_tready got=%b exp=0", s0_tready); end
        @(negedge eth_clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (frame_cnt0 !== 32'd0) begin failures++; $display("FAIL rst_cnt0 got=%0d exp=0", frame_cnt0); end
        checks++; if (frame_cnt1 !== 32'd0) begin failures++; $display("FAIL rst_cnt1 got=%0d exp=0", frame_cnt1); end
        checks++; if (eth_tx_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid2 got=%b exp=0", eth_tx_tvalid); end
        sys_rst156 = 0;
        idle_inputs();
    endtask

    task automatic test_tie();
        int b0 = 0, b1 = 0, f0 = 0, f1 = 0;
        int ph, src, frm;
        logic x0, x1;
        apply_reset();
        src_en = 2'b11; eth_tx_tready = 1;
        for (int c = 0; c < 16; c++) begin
            s0_tvalid = 1; s0_tdata = mk(0, f0, b0); s0_tkeep = 8'hFF; s0_tlast = (b0 == 2); s0_tuser = 0;
            s1_tvalid = 1; s1_tdata = mk(1, f1, b1); s1_tkeep = 8'hFF; s1_tlast = (b1 == 2); s1_tuser = 0;
            #1;
            ph = c % 4; src = (c / 4) % 2; frm = c / 8;
            checks++; if (busy !== (ph != 0)) begin failures++; $display("FAIL tie_busy c=%0d got=%b exp=%b", c, busy, ph != 0); end
            checks++; if (eth_tx_tvalid !== (ph != 0)) begin failures++; $display("FAIL tie_tvalid c=%0d got=%b exp=%b", c, eth_tx_tvalid, ph != 0); end
            if (ph != 0) begin
                checks++; if (eth_tx_tdata !== mk(src, frm, ph - 1)) begin failures++; $display("FAIL tie_tdata c=%0d got=%h exp=%h", c, eth_tx_tdata, mk(src, frm, ph - 1)); end
                checks++; if (s0_tready !== (src == 0)) begin failures++; $display("FAIL tie_s0_tready c=%0d got=%b exp=%b", c, s0_tready, src == 0); end
                checks++; if (s1_tready !== (src == 1)) begin failures++; $display("FAIL tie_s1_tready c=%0d got=%b exp=%b", c, s1_tready, src == 1); end
            end else begin
                checks++; if ({s0_tready, s1_tready} !== 2'b00) begin failures++; $display("FAIL tie_idle_tready c=%0d got=%b exp=00", c, {s0_tready, s1_tready}); end
            end
            x0 = s0_tready; x1 = s1_tready;
            @(negedge eth_clk);
            if (x0) begin if (b0 == 2) begin b0 = 0; f0++; end else b0++; end
            if (x1) begin if (b1 == 2) begin b1 = 0; f1++; end else b1++; end
        end
        #1;
        checks++; if (frame_cnt0 !== 32'd2) begin failures++; $display("FAIL tie_cnt0 got=%0d exp=2", frame_cnt0); end
        checks++; if (frame_cnt1 !== 32'd2) begin failures++; $display("FAIL tie_cnt1 got=%0d exp=2", frame_cnt1); end
    endtask

    task automatic test_enable();
        apply_reset();
        src_en = 2'b01; eth_tx_tready = 1;
        s1_tvalid = 1; s1_tdata = mk(1, 0, 0); s1_tkeep = 8'h0F; s1_tlast = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (s1_tready !== 1'b0) begin failures++; $display("FAIL en_s1_tready c=%0d got=%b exp=0", c, s1_tready); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_busy c=%0d got=%b exp=0", c, busy); end
            @(negedge eth_clk);
        end
        src_en = 2'b11;
        #1;
        checks++; if (eth_tx_tvalid !== 1'b0) begin failures++; $display("FAIL en_still_idle got=%b exp=0", eth_tx_tvalid); end
        @(negedge eth_clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL en_gnt_busy got=%b exp=1", busy); end
        checks++; if (s1_tready !== 1'b1) begin failures++; $display("FAIL en_gnt_s1_tready got=%b exp=1", s1_tready); end
        checks++; if (eth_tx_tdata !== mk(1, 0, 0)) begin failures++; $display("FAIL en_gnt_tdata got=%h exp=%h", eth_tx_tdata, mk(1, 0, 0)); end
        checks++; if (eth_tx_tkeep !== 8'h0F) begin failures++; $display("FAIL en_gnt_tkeep got=%h exp=0f", eth_tx_tkeep); end
        @(negedge eth_clk);
        s1_tvalid = 0;
        #1;
        checks++; if (frame_cnt1 !== 32'd1) begin failures++; $display("FAIL en_cnt1 got=%0d exp=1", frame_cnt1); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_done_busy got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        int b = 0, nxt = 0;
        logic x0;
        apply_reset();
        src_en = 2'b11;
        s1_tvalid = 1; s1_tdata = mk(1, 0, 0); s1_tkeep = 8'hFF; s1_tlast = 1;
        for (int c = 0; c < 20 && b < 5; c++) begin
            eth_tx_tready = (c % 2 == 1);
            if (b == 2) src_en[0] = 1'b0;
            s0_tvalid = 1; s0_tdata = mk(0, 0, b); s0_tkeep = 8'hFF; s0_tlast = (b == 4);
            #1;
            checks++; if (s1_tready !== 1'b0) begin failures++; $display("FAIL bp_s1_tready c=%0d got=%b exp=0", c, s1_tready); end
            if (c > 0) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy c=%0d got=%b exp=1", c, busy); end
            end
            if (eth_tx_tvalid && eth_tx_tready) begin
                checks++; if (eth_tx_tdata !== mk(0, 0, nxt)) begin failures++; $display("FAIL bp_tdata c=%0d got=%h exp=%h", c, eth_tx_tdata, mk(0, 0, nxt)); end
                nxt++;
            end
            x0 = s0_tready;
            @(negedge eth_clk);
            if (x0) b++;
        end
        s0_tvalid = 0; s1_tvalid = 0;
        #1;
        checks++; if (nxt !== 5) begin failures++; $display("FAIL bp_beats got=%0d exp=5", nxt); end
        checks++; if (frame_cnt0 !== 32'd1) begin failures++; $display("FAIL bp_cnt0 got=%0d exp=1", frame_cnt0); end
        checks++; if (frame_cnt1 !== 32'd0) begin failures++; $display("FAIL bp_cnt1 got=%0d exp=0", frame_cnt1); end
    endtask

    task automatic test_gap();
        int   exp_gnt  [12] = '{-1, 0, 0, 0, 0, 0, 0, 0, -1, 1, 1, -1};
        logic exp_vld  [12] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0};
        int   exp_beat [12] = '{0, 0, 1, 0, 0, 0, 2, 3, 0, 0, 1, 0};
        int b0 = 0, b1 = 0, g;
        logic x0, x1;
        logic [7:0] ek;
        apply_reset();
        src_en = 2'b11; eth_tx_tready = 1;
        for (int c = 0; c < 12; c++) begin
            s0_tvalid = (b0 < 4) && !(c >= 3 && c <= 5);
            s0_tdata = mk(0, 0, b0); s0_tkeep = 8'hFF; s0_tlast = (b0 == 3); s0_tuser = 0;
            s1_tvalid = (b1 < 2);
            s1_tdata = mk(1, 0, b1); s1_tkeep = (b1 == 1) ? 8'h0F : 8'hFF; s1_tlast = (b1 == 1); s1_tuser = 1;
            #1;
            g = exp_gnt[c];
            checks++; if (busy !== (g >= 0)) begin failures++; $display("FAIL gap_busy c=%0d got=%b exp=%b", c, busy, g >= 0); end
            checks++; if (eth_tx_tvalid !== exp_vld[c]) begin failures++; $display("FAIL gap_tvalid c=%0d got=%b exp=%b", c, eth_tx_tvalid, exp_vld[c]); end
            checks++; if (s0_tready !== (g == 0)) begin failures++; $display("FAIL gap_s0_tready c=%0d got=%b exp=%b", c, s0_tready, g == 0); end
            checks++; if (s1_tready !== (g == 1)) begin failures++; $display("FAIL gap_s1_tready c=%0d got=%b exp=%b", c, s1_tready, g == 1); end
            if (exp_vld[c]) begin
                ek = (g == 1 && exp_beat[c] == 1) ? 8'h0F : 8'hFF;
                checks++; if (eth_tx_tdata !== mk(g, 0, exp_beat[c])) begin failures++; $display("FAIL gap_tdata c=%0d got=%h exp=%h", c, eth_tx_tdata, mk(g, 0, exp_beat[c])); end
                checks++; if (eth_tx_tuser !== (g == 1)) begin failures++; $display("FAIL gap_tuser c=%0d got=%b exp=%b", c, eth_tx_tuser, g == 1); end
                checks++; if (eth_tx_tkeep !== ek) begin failures++; $display("FAIL gap_tkeep c=%0d got=%h exp=%h", c, eth_tx_tkeep, ek); end
            end
            x0 = s0_tvalid && s0_tready; x1 = s1_tvalid && s1_tready;
            @(negedge eth_clk);
            if (x0) b0++;
            if (x1) b1++;
        end
        #1;
        checks++; if (frame_cnt0 !== 32'd1) begin failures++; $display("FAIL gap_cnt0 got=%0d exp=1", frame_cnt0); end
        checks++; if (frame_cnt1 !== 32'd1) begin failures++; $display("FAIL gap_cnt1 got=%0d exp=1", frame_cnt1); end
    endtask

    task automatic test_wrap();
        apply_reset();
        force dut.frame_cnt1 = 32'hFFFF_FFFF;
        #1;
        release dut.frame_cnt1;
        #1;
        checks++; if (frame_cnt1 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffffffff", frame_cnt1); end
        src_en = 2'b10; eth_tx_tready = 1;
        s1_tvalid = 1; s1_tdata = mk(1, 7, 0); s1_tkeep = 8'hFF; s1_tlast = 1;
        @(negedge eth_clk);
        #1;
        checks++; if (s1_tready !== 1'b1) begin failures++; $display("FAIL wrap_gnt got=%b exp=1", s1_tready); end
        @(negedge eth_clk);
        s1_tvalid = 0;
        #1;
        checks++; if (frame_cnt1 !== 32'd0) begin failures++; $display("FAIL wrap_cnt1 got=%h exp=0", frame_cnt1); end
        checks++; if (frame_cnt0 !== 32'd0) begin failures++; $display("FAIL wrap_cnt0 got=%h exp=0", frame_cnt0); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        src_en = 2'b11; eth_tx_tready = 1;
        s0_tvalid = 1; s0_tdata = mk(0, 0, 0); s0_tkeep = 8'hFF; s0_tlast = 1;
        s1_tvalid = 1; s1_tdata = mk(1, 0, 0); s1_tkeep = 8'hFF; s1_tlast = 0;
        @(negedge eth_clk);
        #1;
        checks++; if (eth_tx_tdata !== mk(0, 0, 0)) begin failures++; $display("FAIL rm_first got=%h exp=%h", eth_tx_tdata, mk(0, 0, 0)); end
        @(negedge eth_clk);
        s0_tvalid = 0;
        #1;
        checks++; if (frame_cnt0 !== 32'd1) begin failures++; $display("FAIL rm_cnt0_pre got=%0d exp=1", frame_cnt0); end
        for (int b = 0; b < 2; b++) begin
            @(negedge eth_clk);
            s1_tdata = mk(1, 0, b);
            #1;
            checks++; if (eth_tx_tdata !== mk(1, 0, b)) begin failures++; $display("FAIL rm_s1_beat b=%0d got=%h exp=%h", b, eth_tx_tdata, mk(1, 0, b)); end
        end
        @(negedge eth_clk);
        s1_tdata = mk(1, 0, 2);
        sys_rst156 = 1;
        #1;
        checks++; if (eth_tx_tvalid !== 1'b0) begin failures++; $display("FAIL rm_rst_tvalid got=%b exp=0", eth_tx_tvalid); end
        checks++; if (s1_tready !== 1'b0) begin failures++; $display("FAIL rm_rst_s1_tready got=%b exp=0", s1_tready); end
        @(negedge eth_clk);
        sys_rst156 = 0;
        s0_tvalid = 1; s0_tdata = mk(0, 1, 0); s0_tlast = 1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy); end
        checks++; if (eth_tx_tvalid !== 1'b0) begin failures++; $display("FAIL rm_idle_tvalid got=%b exp=0", eth_tx_tvalid); end
        checks++; if (frame_cnt0 !== 32'd0) begin failures++; $display("FAIL rm_cnt0 got=%0d exp=0", frame_cnt0); end
        checks++; if (frame_cnt1 !== 32'd0) begin failures++; $display("FAIL rm_cnt1 got=%0d exp=0", frame_cnt1); end
        @(negedge eth_clk);
        #1;
        checks++; if (s0_tready !== 1'b1) begin failures++; $display("FAIL rm_tie_s0 got=%b exp=1", s0_tready); end
        checks++; if (s1_tready !== 1'b0) begin failures++; $display("FAIL rm_tie_s1 got=%b exp=0", s1_tready); end
        checks++; if (eth_tx_tdata !== mk(0, 1, 0)) begin failures++; $display("FAIL rm_tie_tdata got=%h exp=%h", eth_tx_tdata, mk(0, 1, 0)); end
    endtask

    initial begin
        sys_rst156 = 1;
        idle_inputs();
        test_reset();
        test_tie();
        test_enable();
        test_backpressure();
        test_gap();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
